forwarding_unit: RTL and testbench
==================================

# forwarding_unit

Combinational operand-forwarding block for the execute stage of the pipelined datapath. It replaces the register-file operands A and B with a more recent in-flight result whenever a source register matches a pending destination register. Two pending writers are checked, and the pair-2 writer (Rdest2/FinalResult2) has priority. It also provides registered per-operand select codes for hazard and debug observation.

## Interface
Parameters:
- DATA_W, 32, operand and result width
- REG_W, 4, register-index width

Ports:
- clk  in  1  clock; used only by the select-code registers
- rst  in  1  asynchronous, active-high reset
- branchBoolean  in  1  current instruction is a branch; suppresses forwarding on operand A
- immediateBoolean  in  1  operand B is an immediate; suppresses forwarding on operand B
- regwBoolean  in  1  writer 1 will write its destination register
- regwBoolean2  in  1  writer 2 will write its destination register
- R1  in  REG_W  source register index for operand A
- R2  in  REG_W  source register index for operand B
- Rdest  in  REG_W  destination register of writer 1
- Rdest2  in  REG_W  destination register of writer 2
- A  in  DATA_W  register-file value for operand A
- B  in  DATA_W  register-file value for operand B
- FinalResult  in  DATA_W  result value of writer 1
- FinalResult2  in  DATA_W  result value of writer 2
- AOUT  out  DATA_W  forwarded operand A
- BOUT  out  DATA_W  forwarded operand B
- asel_q  out  2  registered select code for operand A
- bsel_q  out  2  registered select code for operand B

## Operation
- Operand A, evaluated in priority order:
  - if !branchBoolean && regwBoolean2 && R1==Rdest2: AOUT = FinalResult2, code 2'b10
  - else if !branchBoolean && regwBoolean && R1==Rdest: AOUT = FinalResult, code 2'b01
  - else AOUT = A, code 2'b00
- Operand B uses the identical rule with R2 in place of R1, immediateBoolean in place of branchBoolean, and B as the fallback value.
- Writer 2 beats writer 1 whenever both match.
- branchBoolean affects only A; immediateBoolean affects only B.
- No register index is special. Index 0 forwards like any other index.
- Comparison is full REG_W-bit equality. Data passes through unmodified, with no width change or arithmetic.
- Code 2'b11 is never produced.

## Timing
- AOUT/BOUT are purely combinational from the inputs: zero-cycle latency, valid within the same cycle.
- AOUT/BOUT do not depend on clk or rst; reset does not force them.
- asel_q/bsel_q capture the current select codes on each rising clk edge, giving a one-cycle delay.
- rst asserted (any time, asynchronous): asel_q = bsel_q = 2'b00 immediately, held while rst is high.
- First capture occurs on the first rising clk edge after rst deasserts.
- Inputs changing mid-cycle update AOUT/BOUT immediately; the registers sample only at the edge.
- No handshake is used.

## Structure
- Shared package fwd_pkg holds:
  - typedef enum logic [1:0] fwd_sel_e {FWD_REG=2'b00, FWD_FR1=2'b01, FWD_FR2=2'b10}
  - the DATA_W/REG_W defaults
- Sub-module fwd_operand_mux, instantiated twice (A and B):
  - inputs: suppress flag, source index, both writer indices and write-enables, fallback value, both results
  - outputs: forwarded value, fwd_sel_e code
- Top level contains the two instances plus the asel_q/bsel_q register block with asynchronous reset.

## Test plan
- branch=0, imm=0, R1=R2=Rdest=Rdest2=2, regw=regw2=1, A=10, B=11, FR=8, FR2=5 -> AOUT=5, BOUT=5; after one clk, asel_q=bsel_q=2'b10.
- Same inputs with branch=1 -> AOUT=10, BOUT=5.
- Same inputs with imm=1 (branch=0) -> AOUT=5, BOUT=11.
- Same inputs with branch=1, imm=1 -> AOUT=10, BOUT=11; codes 2'b00.
- branch=imm=0, regw=1, regw2=0, all indices 2 -> AOUT=8, BOUT=8, codes 2'b01. Then set Rdest=3 -> AOUT=10, BOUT=11.
- rst pulsed mid-cycle while codes are 2'b10 -> asel_q/bsel_q go to 2'b00 without waiting for a clk edge; AOUT/BOUT are unaffected.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding block: default widths and
// the per-operand select code reported by each forwarding mux.
package fwd_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 4;

  // Which source supplied an operand; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_FR1 = 2'b01,
    FWD_FR2 = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_operand_mux.sv
// Single-operand forwarding mux. Picks the most recent in-flight result whose
// destination matches the source index, writer 2 first, else the register value.
// Ports:
//   suppress     - disable forwarding for this operand (branch / immediate)
//   srcIdx       - source register index of the operand
//   rdest1/2     - destination indices of writers 1 and 2
//   regw1/2      - write enables of writers 1 and 2
//   regValue     - register-file value (fallback)
//   result1/2    - result values of writers 1 and 2
//   fwdValue_c   - forwarded operand (combinational)
//   fwdSel_c     - select code (combinational)
module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              suppress,
  input  logic [REG_W-1:0]  srcIdx,
  input  logic [REG_W-1:0]  rdest1,
  input  logic [REG_W-1:0]  rdest2,
  input  logic              regw1,
  input  logic              regw2,
  input  logic [DATA_W-1:0] regValue,
  input  logic [DATA_W-1:0] result1,
  input  logic [DATA_W-1:0] result2,
  output logic [DATA_W-1:0] fwdValue_c,
  output fwd_sel_e          fwdSel_c
);

  logic hit1;
  logic hit2;

  // Full-width index compare; index 0 is not special.
  assign hit1 = !suppress && regw1 && (srcIdx == rdest1);
  assign hit2 = !suppress && regw2 && (srcIdx == rdest2);

  // Writer 2 is younger, so it wins when both match.
  always_comb begin
    fwdValue_c = regValue;
    fwdSel_c   = FWD_REG;
    if (hit2) begin
      fwdValue_c = result2;
      fwdSel_c   = FWD_FR2;
    end else if (hit1) begin
      fwdValue_c = result1;
      fwdSel_c   = FWD_FR1;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Execute-stage operand forwarding. AOUT/BOUT are combinational; the select
// codes are additionally registered for hazard/debug observation.
// Ports:
//   clk, rst          - clock and async active-high reset (select registers only)
//   branchBoolean     - suppresses forwarding on operand A
//   immediateBoolean  - suppresses forwarding on operand B
//   regwBoolean(2)    - write enables of writers 1 and 2
//   R1, R2            - source indices of operands A and B
//   Rdest, Rdest2     - destination indices of writers 1 and 2
//   A, B              - register-file operand values
//   FinalResult(2)    - result values of writers 1 and 2
//   AOUT, BOUT        - forwarded operands
//   asel_q, bsel_q    - select codes delayed by one clock
module forwarding_unit
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branchBoolean,
  input  logic              immediateBoolean,
  input  logic              regwBoolean,
  input  logic              regwBoolean2,
  input  logic [REG_W-1:0]  R1,
  input  logic [REG_W-1:0]  R2,
  input  logic [REG_W-1:0]  Rdest,
  input  logic [REG_W-1:0]  Rdest2,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [DATA_W-1:0] FinalResult,
  input  logic [DATA_W-1:0] FinalResult2,
  output logic [DATA_W-1:0] AOUT,
  output logic [DATA_W-1:0] BOUT,
  output logic [1:0]        asel_q,
  output logic [1:0]        bsel_q
);

  fwd_sel_e aSel;
  fwd_sel_e bSel;

  fwd_operand_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) aMux (
    .suppress   (branchBoolean),
    .srcIdx     (R1),
    .rdest1     (Rdest),
    .rdest2     (Rdest2),
    .regw1      (regwBoolean),
    .regw2      (regwBoolean2),
    .regValue   (A),
    .result1    (FinalResult),
    .result2    (FinalResult2),
    .fwdValue_c (AOUT),
    .fwdSel_c   (aSel)
  );

  fwd_operand_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) bMux (
    .suppress   (immediateBoolean),
    .srcIdx     (R2),
    .rdest1     (Rdest),
    .rdest2     (Rdest2),
    .regw1      (regwBoolean),
    .regw2      (regwBoolean2),
    .regValue   (B),
    .result1    (FinalResult),
    .result2    (FinalResult2),
    .fwdValue_c (BOUT),
    .fwdSel_c   (bSel)
  );

  // Select-code capture; reset clears immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asel_q <= 2'b00;
      bsel_q <= 2'b00;
    end else begin
      asel_q <= 2'(aSel);
      bsel_q <= 2'(bSel);
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
module tb_forwarding_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              branchBoolean, immediateBoolean, regwBoolean, regwBoolean2;
  logic [REG_W-1:0]  R1, R2, Rdest, Rdest2;
  logic [DATA_W-1:0] A, B, FinalResult, FinalResult2;
  logic [DATA_W-1:0] AOUT, BOUT;
  logic [1:0]        asel_q, bsel_q;

  int nTests = 0;
  int nFail  = 0;

  forwarding_unit #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .branchBoolean    (branchBoolean),
    .immediateBoolean (immediateBoolean),
    .regwBoolean      (regwBoolean),
    .regwBoolean2     (regwBoolean2),
    .R1               (R1),
    .R2               (R2),
    .Rdest            (Rdest),
    .Rdest2           (Rdest2),
    .A                (A),
    .B                (B),
    .FinalResult      (FinalResult),
    .FinalResult2     (FinalResult2),
    .AOUT             (AOUT),
    .BOUT             (BOUT),
    .asel_q           (asel_q),
    .bsel_q           (bsel_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              br, imm, regw, regw2;
    logic [REG_W-1:0]  r1, r2, rd, rd2;
    logic [DATA_W-1:0] a, b, fr, fr2;
    logic [DATA_W-1:0] expA, expB;
    logic [1:0]        expASel, expBSel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    branchBoolean    = v.br;
    immediateBoolean = v.imm;
    regwBoolean      = v.regw;
    regwBoolean2     = v.regw2;
    R1 = v.r1; R2 = v.r2; Rdest = v.rd; Rdest2 = v.rd2;
    A = v.a; B = v.b; FinalResult = v.fr; FinalResult2 = v.fr2;
  endtask

  // Reference: walk the pending writers youngest-first and take the first one
  // that writes the source register; otherwise keep the register value.
  task automatic refOperand(input logic sup, input logic [REG_W-1:0] src,
                            input vec_t v, output logic [DATA_W-1:0] val,
                            output logic [1:0] code);
    logic              wen[2];
    logic [REG_W-1:0]  wdst[2];
    logic [DATA_W-1:0] wval[2];
    logic [1:0]        wcode[2];
    logic              found;
    wen[0] = v.regw2; wdst[0] = v.rd2; wval[0] = v.fr2; wcode[0] = 2;
    wen[1] = v.regw;  wdst[1] = v.rd;  wval[1] = v.fr;  wcode[1] = 1;
    val = (src == v.r1 && sup == v.br) ? v.a : v.b;
    code = 0;
    found = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!found && !sup && wen[i] && wdst[i] == src) begin
        val = wval[i]; code = wcode[i]; found = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [DATA_W-1:0] eA, eB;
    logic [1:0] cA, cB;

    // Directed table: {br,imm,regw,regw2, r1,r2,rd,rd2, a,b,fr,fr2, expA,expB, aSel,bSel}
    vecs.push_back('{0,0,1,1, 2,2,2,2, 10,11,8,5,  5, 5, 2'b10,2'b10});
    vecs.push_back('{1,0,1,1, 2,2,2,2, 10,11,8,5, 10, 5, 2'b00,2'b10});
    vecs.push_back('{0,1,1,1, 2,2,2,2, 10,11,8,5,  5,11, 2'b10,2'b00});
    vecs.push_back('{1,1,1,1, 2,2,2,2, 10,11,8,5, 10,11, 2'b00,2'b00});
    vecs.push_back('{0,0,1,0, 2,2,2,2, 10,11,8,5,  8, 8, 2'b01,2'b01});
    vecs.push_back('{0,0,1,0, 2,2,3,2, 10,11,8,5, 10,11, 2'b00,2'b00});
    vecs.push_back('{0,0,1,1, 0,0,0,0, 7,9,32'hAAAA_0001,32'h5555_0002,
                     32'h5555_0002,32'h5555_0002, 2'b10,2'b10});
    vecs.push_back('{0,0,1,1, 3,4,4,3, 1,2,32'hDEAD_BEEF,32'hFFFF_FFFF,
                     32'hFFFF_FFFF,32'hDEAD_BEEF, 2'b10,2'b01});
    vecs.push_back('{0,0,0,0, 5,5,5,5, 32'h1234,32'h5678,1,2, 32'h1234,32'h5678, 2'b00,2'b00});
    vecs.push_back('{0,0,1,1, 15,15,15,14, 3,4,6,7, 6,6, 2'b01,2'b01});

    branchBoolean = 0; immediateBoolean = 0; regwBoolean = 0; regwBoolean2 = 0;
    R1 = 0; R2 = 0; Rdest = 0; Rdest2 = 0; A = 0; B = 0; FinalResult = 0; FinalResult2 = 0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    check("reset_asel", 32'(asel_q), 0);
    check("reset_bsel", 32'(bsel_q), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d_AOUT", i), AOUT, vecs[i].expA);
      check($sformatf("vec%0d_BOUT", i), BOUT, vecs[i].expB);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_asel", i), 32'(asel_q), 32'(vecs[i].expASel));
      check($sformatf("vec%0d_bsel", i), 32'(bsel_q), 32'(vecs[i].expBSel));
    end

    // Mid-cycle input change: outputs follow at once, registers hold
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #2;
    R1 = 4'd9;
    #1;
    check("midcycle_AOUT", AOUT, 10);
    check("midcycle_asel_hold", 32'(asel_q), 2);
    @(posedge clk);
    #1;
    check("midcycle_asel_next", 32'(asel_q), 0);

    // Async reset mid-cycle while codes are 2'b10
    @(negedge clk);
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check("prerst_asel", 32'(asel_q), 2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_asel", 32'(asel_q), 0);
    check("rst_async_bsel", 32'(bsel_q), 0);
    check("rst_AOUT", AOUT, 5);
    check("rst_BOUT", BOUT, 5);
    @(posedge clk);
    #1;
    check("rst_held_asel", 32'(asel_q), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst_asel", 32'(asel_q), 2);
    check("postrst_bsel", 32'(bsel_q), 2);

    // Randomized against reference model; small index range forces matches
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      v.br = 1'($urandom); v.imm = 1'($urandom);
      v.regw = 1'($urandom); v.regw2 = 1'($urandom);
      v.r1 = REG_W'($urandom_range(0, 3)); v.r2 = REG_W'($urandom_range(0, 3));
      v.rd = REG_W'($urandom_range(0, 3)); v.rd2 = REG_W'($urandom_range(0, 3));
      v.a = $urandom; v.b = $urandom; v.fr = $urandom; v.fr2 = $urandom;
      drive(v);
      refOperand(v.br, v.r1, v, eA, cA);
      // Fallback for B is B regardless of index coincidence.
      refOperand(v.imm, v.r2, v, eB, cB);
      if (cA == 0) eA = v.a;
      if (cB == 0) eB = v.b;
      #1;
      check($sformatf("rnd%0d_AOUT", n), AOUT, eA);
      check($sformatf("rnd%0d_BOUT", n), BOUT, eB);
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d_asel", n), 32'(asel_q), 32'(cA));
      check($sformatf("rnd%0d_bsel", n), 32'(bsel_q), 32'(cB));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
